// File: rtl/serdes_n.sv
// -----------------------------------------------------------------------------
// serdes_n -- parametrised full-duplex shift engine.
//
// Serialises a WIDTH-bit word onto o_sout while deserialising i_sin into a
// WIDTH-bit word. Each i_bit_en strobe moves one bit in each direction. Bit
// pacing comes from an external tick generator. Framing is left to the
// protocol FSM that drives the valid/ready handshake.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 travels first, 0: bit 0 travels first
//   IDLE_LVL   level held on o_sout outside a frame
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   i_bit_en     single-cycle shift strobe (used only while shifting)
//   i_abort      synchronous abort of the frame in progress
//   i_tx_data    word to transmit, sampled at acceptance
//   i_tx_valid   i_tx_data is valid
//   o_tx_ready   block is idle and will accept a word
//   i_sin        serial input, already synchronised to clk
//   o_sout       serial output, driven from a flop
//   o_rx_data    last completely received word
//   o_rx_valid   one-cycle pulse: o_rx_data just updated
//   o_busy       frame in progress
// -----------------------------------------------------------------------------
module serdes_n #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bit_en,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy
);

  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_tx_sr;     // bits still to be sent, next one at the head
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_sout;

  logic             w_last;
  logic             w_tx_first;
  logic [WIDTH-1:0] w_tx_load;
  logic             w_tx_head;
  logic [WIDTH-1:0] w_tx_shift;
  logic [WIDTH-1:0] w_rx_shift;

  // The first bit goes straight to r_sout at acceptance, so the shift
  // register is loaded with the word already advanced by one position.
  // Its head then always holds the bit that the next strobe presents.
  assign w_tx_first = MSB_FIRST ? i_tx_data[WIDTH-1] : i_tx_data[0];
  assign w_tx_load  = MSB_FIRST ? {i_tx_data[WIDTH-2:0], 1'b0}
                                : {1'b0, i_tx_data[WIDTH-1:1]};
  assign w_tx_head  = MSB_FIRST ? r_tx_sr[WIDTH-1] : r_tx_sr[0];
  assign w_tx_shift = MSB_FIRST ? {r_tx_sr[WIDTH-2:0], 1'b0}
                                : {1'b0, r_tx_sr[WIDTH-1:1]};

  // The first bit received must end up in the same position it was sent
  // from. MSB-first therefore shifts in at bit 0, and LSB-first at the top.
  assign w_rx_shift = MSB_FIRST ? {r_rx_sr[WIDTH-2:0], i_sin}
                                : {i_sin, r_rx_sr[WIDTH-1:1]};

  // The counter is cleared at acceptance. This strobe therefore carries the
  // WIDTH-th bit.
  assign w_last = (r_cnt == LAST_IDX);

  // NOTE: sequential state is updated with non-blocking assignments only.
  // All flops then sample their inputs as they stood before the edge. This
  // ordering lets rx sampling and tx advance share the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default before the case. This
  // keeps the block purely combinational, and no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_tx_valid)                       w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (i_abort || (i_bit_en && w_last))  w_state_nxt = ST_IDLE;
      default:                                        w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the shift registers are cleared by reset as well. A frame cut
  // short by reset then leaves no stale bits visible on any output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sout     <= IDLE_LVL;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_tx_valid) begin
            r_tx_sr <= w_tx_load;
            r_sout  <= w_tx_first;
            r_cnt   <= '0;
            r_rx_sr <= '0;
          end
        end
        ST_SHIFT: begin
          // abort outranks bit_en. The partial rx word is never published.
          if (i_abort) begin
            r_sout <= IDLE_LVL;
          end else if (i_bit_en) begin
            r_rx_sr <= w_rx_shift;
            r_tx_sr <= w_tx_shift;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              r_rx_data  <= w_rx_shift;
              r_rx_valid <= 1'b1;
              r_sout     <= IDLE_LVL;
            end else begin
              r_sout <= w_tx_head;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_ready = (r_state == ST_IDLE);
  assign o_busy     = (r_state == ST_SHIFT);
  assign o_sout     = r_sout;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;

endmodule

// File: tb/tb_serdes_n.sv
// -----------------------------------------------------------------------------
// tb_serdes_n -- self-checking bench for serdes_n.
//
// Three instances share clk, rst, bit_en, abort and tx_valid:
//   0: WIDTH=8,  MSB_FIRST=1, IDLE_LVL=0
//   1: WIDTH=8,  MSB_FIRST=0, IDLE_LVL=1
//   2: WIDTH=12, MSB_FIRST=1, IDLE_LVL=0
// The reference model describes a frame as a word plus a bit index k.
// sout carries word[pos(k)], and each received bit lands at pos(k). After
// every clock edge, all outputs of every instance are compared with the model.
// -----------------------------------------------------------------------------
module tb_serdes_n;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic bit_en, abort, tx_valid;
  logic [31:0] tx_data [N];
  logic        drv_sin [N];
  logic        loopb   [N];

  logic [N-1:0] tx_ready, sout, busy, rx_valid, sin;
  logic [7:0]   rx_data0, rx_data1;
  logic [11:0]  rx_data2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign sin[0] = loopb[0] ? sout[0] : drv_sin[0];
  assign sin[1] = loopb[1] ? sout[1] : drv_sin[1];
  assign sin[2] = loopb[2] ? sout[2] : drv_sin[2];

  serdes_n #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u0 (
    .clk(clk), .rst(rst), .i_bit_en(bit_en), .i_abort(abort),
    .i_tx_data(tx_data[0][7:0]), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready[0]),
    .i_sin(sin[0]), .o_sout(sout[0]), .o_rx_data(rx_data0),
    .o_rx_valid(rx_valid[0]), .o_busy(busy[0]));

  serdes_n #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u1 (
    .clk(clk), .rst(rst), .i_bit_en(bit_en), .i_abort(abort),
    .i_tx_data(tx_data[1][7:0]), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready[1]),
    .i_sin(sin[1]), .o_sout(sout[1]), .o_rx_data(rx_data1),
    .o_rx_valid(rx_valid[1]), .o_busy(busy[1]));

  serdes_n #(.WIDTH(12), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u2 (
    .clk(clk), .rst(rst), .i_bit_en(bit_en), .i_abort(abort),
    .i_tx_data(tx_data[2][11:0]), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready[2]),
    .i_sin(sin[2]), .o_sout(sout[2]), .o_rx_data(rx_data2),
    .o_rx_valid(rx_valid[2]), .o_busy(busy[2]));

  // ---------------- reference model ----------------
  function automatic int wd(input int d);
    return (d == 2) ? 12 : 8;
  endfunction
  function automatic bit mf(input int d);
    return (d != 1);
  endfunction
  function automatic logic il(input int d);
    return (d == 1) ? 1'b1 : 1'b0;
  endfunction
  // Word bit position that travels as the k-th bit of a frame.
  function automatic int pos(input int d, input int k);
    return mf(d) ? (wd(d) - 1 - k) : k;
  endfunction

  bit          m_act  [N];
  int          m_k    [N];
  logic [31:0] m_word [N];
  logic [31:0] m_asm  [N];
  logic [31:0] m_rxd  [N];
  logic        m_rxv  [N];

  function automatic logic m_sout(input int d);
    if (m_act[d]) return m_word[d][pos(d, m_k[d])];
    return il(d);
  endfunction

  function automatic logic [31:0] dut_rxd(input int d);
    case (d)
      0:       return {24'b0, rx_data0};
      1:       return {24'b0, rx_data1};
      default: return {20'b0, rx_data2};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_act[d] = 0; m_k[d] = 0; m_asm[d] = '0; m_rxd[d] = '0; m_rxv[d] = 1'b0;
    end
  endtask

  // Applies one clock edge to the model, using the inputs currently driven.
  task automatic model_edge();
    logic sv;
    for (int d = 0; d < N; d++) begin
      sv = loopb[d] ? m_sout(d) : drv_sin[d];
      m_rxv[d] = 1'b0;
      if (!m_act[d]) begin
        if (tx_valid) begin
          m_act[d] = 1; m_k[d] = 0; m_word[d] = tx_data[d]; m_asm[d] = '0;
        end
      end else if (abort) begin
        m_act[d] = 0;
      end else if (bit_en) begin
        m_asm[d][pos(d, m_k[d])] = sv;
        m_k[d]++;
        if (m_k[d] == wd(d)) begin
          m_rxd[d] = m_asm[d]; m_rxv[d] = 1'b1; m_act[d] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < N; d++) begin
      check($sformatf("u%0d.sout@%0t", d, $time),     {31'b0, sout[d]},     {31'b0, m_sout(d)});
      check($sformatf("u%0d.tx_ready@%0t", d, $time), {31'b0, tx_ready[d]}, {31'b0, !m_act[d]});
      check($sformatf("u%0d.busy@%0t", d, $time),     {31'b0, busy[d]},     {31'b0, m_act[d]});
      check($sformatf("u%0d.rx_valid@%0t", d, $time), {31'b0, rx_valid[d]}, {31'b0, m_rxv[d]});
      check($sformatf("u%0d.rx_data@%0t", d, $time),  dut_rxd(d),           m_rxd[d]);
    end
  endtask

  // One clock: advance the model, let the edge pass, then compare.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int pulses;
    rst = 1'b1; bit_en = 1'b0; abort = 1'b0; tx_valid = 1'b0;
    for (int d = 0; d < N; d++) begin
      tx_data[d] = '0; drv_sin[d] = 1'b0; loopb[d] = 1'b1;
    end
    model_reset();
    #2;
    compare_all();
    check("reset.rx_data0", dut_rxd(0), 32'h0);
    check("reset.sout1_idle_high", {31'b0, sout[1]}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Looped frames, strobe every 4 clocks: A5 / random / F0F.
    tx_data[0] = 32'hA5; tx_data[1] = $urandom & 32'hFF; tx_data[2] = 32'hF0F;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    check("t1.first_bit_msb", {31'b0, sout[0]}, 32'h1);
    for (int s = 0; s < 12; s++) begin
      bit_en = 1'b0;
      repeat (3) cyc();
      bit_en = 1'b1;
      cyc();
      if (s == 7) begin
        check("t1.rx_valid0_after_8th", {31'b0, rx_valid[0]}, 32'h1);
        check("t1.busy0_low", {31'b0, busy[0]}, 32'h0);
        check("t1.tx_ready0_high", {31'b0, tx_ready[0]}, 32'h1);
        check("t1.u2_still_busy", {31'b0, busy[2]}, 32'h1);
      end
      if (s == 11) check("t1.rx_valid2_after_12th", {31'b0, rx_valid[2]}, 32'h1);
    end
    bit_en = 1'b0;
    cyc();
    check("t1.rx_data0", dut_rxd(0), 32'hA5);
    check("t1.rx_data2", dut_rxd(2), 32'hF0F);

    // LSB-first 0x01 with sin driven 1,1,0,...
    loopb[1] = 1'b0;
    tx_data[0] = $urandom & 32'hFF; tx_data[1] = 32'h01; tx_data[2] = $urandom & 32'hFFF;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    check("t2.first_bit_lsb", {31'b0, sout[1]}, 32'h1);
    for (int s = 0; s < 12; s++) begin
      drv_sin[1] = (s < 2);
      bit_en = 1'b0;
      cyc();
      bit_en = 1'b1;
      cyc();
    end
    bit_en = 1'b0;
    check("t2.rx_data1", dut_rxd(1), 32'h03);
    loopb[1] = 1'b1;

    // bit_en tied high, tx_valid held: 3C then C3 back to back.
    bit_en = 1'b1; tx_valid = 1'b1; pulses = 0;
    tx_data[0] = 32'h3C; tx_data[1] = 32'h3C; tx_data[2] = $urandom & 32'hFFF;
    cyc();
    tx_data[0] = 32'hC3; tx_data[1] = 32'hC3;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (rx_valid[0]) pulses++;
      if (c == 8) check("t3.gap_sout0_idle", {31'b0, sout[0]}, 32'h0);
    end
    tx_valid = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      cyc();
      if (rx_valid[0]) pulses++;
    end
    check("t3.rx_valid0_pulses", pulses, 2);
    check("t3.rx_data0", dut_rxd(0), 32'hC3);
    repeat (4) cyc();

    // Reload A5 into rx_data0, then tx_valid mid-frame is ignored, then abort.
    tx_data[0] = 32'hA5; tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    repeat (12) cyc();
    check("t4.prior_rx_data0", dut_rxd(0), 32'hA5);
    bit_en = 1'b0;
    tx_data[0] = 32'h96; tx_data[1] = $urandom & 32'hFF; tx_data[2] = $urandom & 32'hFFF;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) begin tx_valid = 1'b1; tx_data[0] = 32'hFF; end
      bit_en = 1'b0;
      cyc();
      tx_valid = 1'b0;
      bit_en = 1'b1;
      cyc();
    end
    abort = 1'b1; bit_en = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4.abort_busy0", {31'b0, busy[0]}, 32'h0);
    check("t4.abort_sout0", {31'b0, sout[0]}, 32'h0);
    check("t4.abort_no_rx_valid0", {31'b0, rx_valid[0]}, 32'h0);
    check("t4.abort_rx_data0_kept", dut_rxd(0), 32'hA5);
    // abort while idle does not block acceptance.
    abort = 1'b1; tx_valid = 1'b1; bit_en = 1'b0;
    cyc();
    abort = 1'b0; tx_valid = 1'b0;
    check("t4.idle_abort_accepts", {31'b0, busy[0]}, 32'h1);
    bit_en = 1'b1;
    repeat (13) cyc();

    // Asynchronous reset after 5 strobes, then a clean 5A frame.
    tx_data[0] = 32'h77; tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    repeat (5) cyc();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t5.rst_rx_data0", dut_rxd(0), 32'h0);
    check("t5.rst_tx_ready0", {31'b0, tx_ready[0]}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tx_data[0] = 32'h5A; tx_valid = 1'b1; bit_en = 1'b0;
    cyc();
    tx_valid = 1'b0;
    for (int s = 0; s < 12; s++) begin
      bit_en = 1'b0;
      repeat (2) cyc();
      bit_en = 1'b1;
      cyc();
    end
    bit_en = 1'b0;
    check("t5.rx_data0_after_reset", dut_rxd(0), 32'h5A);

    // Random traffic; instance 1 receives an independent random sin.
    loopb[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit_en     = ($urandom_range(0, 2) != 0);
      tx_valid   = ($urandom_range(0, 2) == 0);
      abort      = ($urandom_range(0, 15) == 0);
      drv_sin[1] = $urandom_range(0, 1);
      for (int d = 0; d < N; d++) tx_data[d] = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serdes_n.md
Name: serdes_n

Overview:
- Parametrised full-duplex shift engine: serialises a WIDTH-bit word onto sout while deserialising sin into a WIDTH-bit word, one bit per bit_en strobe.
- Successor to the fixed 8-bit SIPO/PISO pair. Adds width and bit-order parameters, a valid/ready transmit handshake, a receive-valid pulse, abort, and external bit pacing.
- Sits between a clock-divider or tick generator, which supplies bit_en, and protocol FSMs such as SPI or UART framers.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: bit WIDTH-1 is shifted first (tx and rx); 0: bit 0 first.
- IDLE_LVL, 1'b0, level driven on sout when no frame is active.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  single-cycle shift strobe; only meaningful in SHIFT.
- abort  in  1  synchronous abort of the current frame.
- tx_data  in  WIDTH  word to transmit; sampled only at acceptance.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a word.
- sin  in  1  serial input; already synchronised by the instantiator.
- sout  out  1  serial output, registered.
- rx_data  out  WIDTH  last completely received word.
- rx_valid  out  1  one-cycle pulse: rx_data just updated.
- busy  out  1  frame in progress.

Behaviour:
- Reset (async, any time incl. mid-frame): state=IDLE, bit counter=0, tx/rx shift regs=0, rx_data=0, rx_valid=0, sout=IDLE_LVL, busy=0, tx_ready=1. Partial frame discarded.
- State machine: IDLE, SHIFT. tx_ready = (state==IDLE); busy = (state==SHIFT). Both are decoded from the state register only, never from inputs.
- IDLE:
  - sout=IDLE_LVL; bit_en and sin ignored.
  - On an edge with tx_valid&tx_ready: load tx_data into tx shift reg, clear counter and rx shift reg, go SHIFT.
  - sout presents the first bit (MSB_FIRST ? tx_data[WIDTH-1] : tx_data[0]) from that same edge.
- SHIFT, on an edge with bit_en=1:
  - Sample sin into the rx shift reg at the position matching bit order.
  - Advance sout to the next tx bit; increment counter.
  - Sampling and shifting happen on the same edge. The peer therefore sees each sout bit stable for one full bit_en period.
- Frame completion: on the edge where the counter reaches WIDTH (the WIDTH-th bit_en):
  - rx_data <= assembled word, including the bit sampled on that edge.
  - rx_valid=1 for exactly the following cycle.
  - state <= IDLE; sout <= IDLE_LVL.
- Back-to-back frames: tx_ready is high the cycle after completion. A held tx_valid is accepted there, so the minimum gap between frames is one clk cycle.
- SHIFT with bit_en=0: all state holds.
- tx_valid while busy: ignored; tx_data changes mid-frame have no effect.
- abort=1 in SHIFT:
  - Next edge: state <= IDLE, sout <= IDLE_LVL.
  - No rx_valid; rx_data keeps its previous value.
  - abort outranks bit_en on the same edge.
- abort=1 in IDLE: no effect. A simultaneous tx_valid is still accepted.
- Counter: $clog2(WIDTH+1) bits. It never wraps in operation because it is cleared at acceptance.
- rx_data holds its value until the next completion and is not masked by rx_valid.
- bit_en with period 1 (every cycle) is legal. Frame length is then WIDTH cycles after acceptance.

Test Plan:
- WIDTH=8, MSB_FIRST=1, sin looped to sout, bit_en every 4 clks, send 0xA5 -> sout 1,0,1,0,0,1,0,1, each bit held 4 clks; rx_data=0xA5; rx_valid high exactly 1 cycle after the 8th strobe edge; busy low and tx_ready high on that same cycle.
- MSB_FIRST=0, send 0x01 while sin drives 1,1,0,0,0,0,0,0 -> sout first bit 1 then 0s; rx_data=0x03.
- bit_en tied high, tx_valid held high with 0x3C then 0xC3 -> two frames of 8 cycles each separated by exactly 1 idle cycle with sout=IDLE_LVL; two rx_valid pulses.
- Mid-frame: after 3 strobes, pulse tx_valid with new data -> ignored, transmitted word unchanged. Then assert abort together with bit_en -> IDLE next cycle, sout=IDLE_LVL, no rx_valid, rx_data keeps prior 0xA5.
- Assert rst after 5 strobes -> all outputs at reset values asynchronously (rx_data=0, tx_ready=1). A new 0x5A frame after release completes correctly.
- WIDTH=12, MSB_FIRST=1, send 12'hF0F looped -> 12 bits shifted; rx_data=12'hF0F; rx_valid after exactly the 12th strobe.
